// File: rtl/risc_ifetch.sv
// rtl/risc_ifetch.sv - instruction fetch unit between PC, instruction memory and decode
//
// Fetches the word at the PC over a req/ack memory handshake and hands it to decode
// over valid/ready. It pulses pcEn once per fetched word so the PC steps forward.
// A flush (taken branch/jump) drops whatever fetch is in progress.
//
// Ports:
//   clk, rstN                 clock, asynchronous active-low reset
//   pcAddr                    current PC value
//   flush                     redirect pulse (PC loads its target on the same edge)
//   pcEn                      PC advance enable, one pulse per accepted fetch
//   memReq, memAddr           instruction memory read request and address
//   memAck, memData           memory response strobe and read data
//   instrOut, instrPc         fetched instruction and its fetch address
//   instrValid, instrReady    handshake towards decode
//   fetchFault                misaligned-fetch fault
//
// Optional feature: define IFETCH_MISALIGN_TRAP_EN to trap misaligned fetch addresses
// instead of silently aligning them.

`timescale 1ns/1ps

module risc_ifetch #(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter logic [DATA_W-1:0] NOP_INSN = 'h0000_0013
) (
    input  logic              clk,
    input  logic              rstN,
    input  logic [ADDR_W-1:0] pcAddr,
    input  logic              flush,
    output logic              pcEn,
    output logic              memReq,
    output logic [ADDR_W-1:0] memAddr,
    input  logic              memAck,
    input  logic [DATA_W-1:0] memData,
    output logic [DATA_W-1:0] instrOut,
    output logic [ADDR_W-1:0] instrPc,
    output logic              instrValid,
    input  logic              instrReady,
    output logic              fetchFault
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_VALID,
        S_DRAIN,
        S_FAULT
    } state_t;

    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

    state_t            state_q, state_d;
    logic              mem_req_q, mem_req_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              pc_en_q, pc_en_d;
    logic              instr_valid_q, instr_valid_d;
    logic [DATA_W-1:0] instr_out_q, instr_out_d;
    logic [ADDR_W-1:0] instr_pc_q, instr_pc_d;
    logic              fault_q, fault_d;

    logic              misaligned;
    logic [ADDR_W-1:0] issue_addr;
    logic              issue;

`ifdef IFETCH_MISALIGN_TRAP_EN
    assign misaligned = |pcAddr[1:0];
    assign issue_addr = pcAddr;
`else
    assign misaligned = 1'b0;
    assign issue_addr = pcAddr & ALIGN_MASK;
`endif

    always_comb begin
        state_d       = state_q;
        mem_req_d     = mem_req_q;
        mem_addr_d    = mem_addr_q;
        pc_en_d       = 1'b0;
        instr_valid_d = instr_valid_q;
        instr_out_d   = instr_out_q;
        instr_pc_d    = instr_pc_q;
        fault_d       = fault_q;
        issue         = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                // Hold off while the PC is being redirected; pcAddr still shows the old PC.
                if (!flush) begin
                    issue = 1'b1;
                end
            end
            S_REQ: begin
                if (flush) begin
                    if (memAck) begin
                        mem_req_d = 1'b0;
                        state_d   = S_IDLE;
                    end else begin
                        state_d   = S_DRAIN;
                    end
                end else if (memAck) begin
                    instr_out_d   = memData;
                    instr_pc_d    = mem_addr_q;
                    instr_valid_d = 1'b1;
                    mem_req_d     = 1'b0;
                    pc_en_d       = 1'b1;
                    state_d       = S_VALID;
                end
            end
            S_VALID: begin
                if (flush) begin
                    instr_valid_d = 1'b0;
                    instr_out_d   = NOP_INSN;
                    state_d       = S_IDLE;
                end else if (instrReady) begin
                    instr_valid_d = 1'b0;
                    instr_out_d   = NOP_INSN;
                    // While pcEn is still high the PC has not advanced yet, so the next
                    // request goes out one cycle later from IDLE.
                    if (pc_en_q) begin
                        state_d = S_IDLE;
                    end else begin
                        issue = 1'b1;
                    end
                end
            end
            S_DRAIN: begin
                if (memAck) begin
                    mem_req_d = 1'b0;
                    state_d   = S_IDLE;
                end
            end
            S_FAULT: begin
                if (flush) begin
                    instr_valid_d = 1'b0;
                    instr_out_d   = NOP_INSN;
                    fault_d       = 1'b0;
                    state_d       = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (issue) begin
            if (misaligned) begin
                instr_valid_d = 1'b1;
                instr_out_d   = NOP_INSN;
                instr_pc_d    = pcAddr;
                fault_d       = 1'b1;
                state_d       = S_FAULT;
            end else begin
                mem_req_d  = 1'b1;
                mem_addr_d = issue_addr;
                state_d    = S_REQ;
            end
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q       <= S_IDLE;
            mem_req_q     <= 1'b0;
            mem_addr_q    <= '0;
            pc_en_q       <= 1'b0;
            instr_valid_q <= 1'b0;
            instr_out_q   <= NOP_INSN;
            instr_pc_q    <= '0;
            fault_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            mem_req_q     <= mem_req_d;
            mem_addr_q    <= mem_addr_d;
            pc_en_q       <= pc_en_d;
            instr_valid_q <= instr_valid_d;
            instr_out_q   <= instr_out_d;
            instr_pc_q    <= instr_pc_d;
            fault_q       <= fault_d;
        end
    end

    // A redirect in the pcEn cycle must win: the PC loads the target, not PC+4.
    assign pcEn       = pc_en_q & ~flush;
    assign memReq     = mem_req_q;
    assign memAddr    = mem_addr_q;
    assign instrOut   = instr_out_q;
    assign instrPc    = instr_pc_q;
    assign instrValid = instr_valid_q;
    assign fetchFault = fault_q;

endmodule

// File: tb/tb_risc_ifetch.sv
// tb/tb_risc_ifetch.sv - scoreboard bench for risc_ifetch

`timescale 1ns/1ps

module tb_risc_ifetch;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rstN = 1'b0;
    logic [31:0] pcAddr;
    logic        flush = 1'b0;
    logic        pcEn;
    logic        memReq;
    logic [31:0] memAddr;
    logic        memAck = 1'b0;
    logic [31:0] memData = '0;
    logic [31:0] instrOut;
    logic [31:0] instrPc;
    logic        instrValid;
    logic        instrReady = 1'b0;
    logic        fetchFault;

    risc_ifetch dut (
        .clk(clk), .rstN(rstN), .pcAddr(pcAddr), .flush(flush), .pcEn(pcEn),
        .memReq(memReq), .memAddr(memAddr), .memAck(memAck), .memData(memData),
        .instrOut(instrOut), .instrPc(instrPc), .instrValid(instrValid),
        .instrReady(instrReady), .fetchFault(fetchFault)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%08h required=%08h", nm, act, req);
        end
    endtask

    task automatic check1(input string nm, input logic act, input logic req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0b required=%0b", nm, act, req);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hA5A5_0000;
    endfunction

    // Environment PC: loads the target on flush, otherwise steps by 4 on pcEn.
    logic [31:0] target = '0;
    logic [31:0] pc_q;
    always @(posedge clk or negedge rstN) begin
        if (!rstN)      pc_q <= '0;
        else if (flush) pc_q <= target;
        else if (pcEn)  pc_q <= pc_q + 32'd4;
    end
    assign pcAddr = pc_q;

    // Scoreboard: after any redirect to T, decode must see T, T+4, T+8, ...
    logic [31:0] exp_q[$];
    task automatic load_stream(input logic [31:0] t);
        exp_q.delete();
        for (int k = 0; k < 200; k++) exp_q.push_back((t & ~32'h3) + 32'(4 * k));
    endtask

    int          ready_pct = 100, flush_pct = 0, min_wait = 0, max_wait = 0;
    bit          force_ready0 = 0, flush_on_ack = 0, flush_on_valid = 0, dir_flush = 0;
    bit          fast_mode = 0;
    logic [31:0] dir_target = '0;

    // Stimulus: memory responder, decode readiness, redirects.
    initial begin
        int wait_left = 0;
        bit prev_req  = 0;
        forever begin
            @(negedge clk); #1;
            if (!rstN) begin
                flush = 1'b0; memAck = 1'b0; prev_req = 0;
                continue;
            end
            if (memReq && !prev_req) wait_left = $urandom_range(max_wait, min_wait);
            prev_req = memReq;
            if (memReq && wait_left == 0) begin
                memAck  = 1'b1;
                memData = mem_word(memAddr);
            end else begin
                memAck  = 1'b0;
                memData = $urandom;
                if (memReq) wait_left--;
            end
            instrReady = force_ready0 ? 1'b0 : ($urandom_range(99, 0) < ready_pct);
            if (memAck && flush_on_ack) begin
                flush = 1'b1; target = 32'($urandom_range(63, 0)) * 4;
                load_stream(target); flush_on_ack = 0;
            end else if (flush_on_valid && instrValid && !fetchFault) begin
                instrReady = 1'b1;
                flush = 1'b1; target = 32'($urandom_range(63, 0)) * 4;
                load_stream(target); flush_on_valid = 0;
            end else if (dir_flush) begin
                flush = 1'b1; target = dir_target;
                load_stream(target); dir_flush = 0;
            end else if ($urandom_range(99, 0) < flush_pct) begin
                flush = 1'b1; target = 32'($urandom_range(63, 0)) * 4;
                load_stream(target);
            end else begin
                flush = 1'b0;
            end
        end
    end

    // Monitor: pops the scoreboard on each decode handshake and checks invariants.
    initial begin
        bit          prev_valid = 0, prev_hs = 0, prev_flush = 0, prev_req = 0;
        logic [31:0] prev_addr = '0, prev_out = NOP, last_ack_addr = '0, e;
        bit          exp_pcen = 0, req_dead = 0, accepted, hs;
        int          cyc = 0, last_pcen = -1;
        forever begin
            @(negedge clk); #2;
            if (!rstN) begin
                prev_valid = 0; prev_hs = 0; prev_flush = 0; prev_req = 0;
                exp_pcen = 0; req_dead = 0; last_pcen = -1;
                continue;
            end
            cyc++;
            check1("pcen_pulse", pcEn, exp_pcen && !flush);
            if (memReq && !prev_req) req_dead = 0;
            accepted = memReq && memAck && !flush && !req_dead;
            if (memReq && flush) req_dead = 1;
            if (accepted) last_ack_addr = memAddr;
            if (prev_req && memReq) check("memaddr_hold", memAddr, prev_addr);
            if (instrValid) check1("no_req_while_valid", memReq, 1'b0);
            if (!instrValid) check("nop_when_empty", instrOut, NOP);
            if (prev_valid && !prev_hs && !prev_flush) begin
                check1("valid_hold", instrValid, 1'b1);
                check("instr_hold", instrOut, prev_out);
            end
`ifndef IFETCH_MISALIGN_TRAP_EN
            check1("fault_tied0", fetchFault, 1'b0);
`endif
            hs = instrValid && instrReady && !flush && !fetchFault;
            if (hs) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL sb_empty actual_pc=%08h required=queued entry", instrPc);
                end else begin
                    e = exp_q.pop_front();
                    check("instr_pc", instrPc, e);
                    check("instr_data", instrOut, mem_word(e));
                    check("instr_pc_vs_memaddr", instrPc, last_ack_addr);
                end
            end
            if (!fast_mode) last_pcen = -1;
            else if (pcEn) begin
                if (last_pcen >= 0) check("fetch_period", 32'(cyc - last_pcen), 32'd3);
                last_pcen = cyc;
            end
            exp_pcen   = accepted;
            prev_valid = instrValid; prev_hs = hs; prev_flush = flush;
            prev_req   = memReq;     prev_addr = memAddr; prev_out = instrOut;
        end
    end

    task automatic tick();
        @(negedge clk); #3;
    endtask

    function automatic bit probe(input int w);
        case (w)
            0:       return !memReq;
            1:       return memReq;
            2:       return instrValid;
            3:       return fetchFault;
            4:       return !flush_on_ack;
            5:       return !flush_on_valid;
            default: return !dir_flush;
        endcase
    endfunction

    task automatic wait_until(input int w, input string nm);
        int n = 0;
        while (!probe(w) && n < 60) begin tick(); n++; end
        total++;
        if (!probe(w)) begin
            bad++;
            $display("FAIL %s timeout actual=not reached required=reached", nm);
        end
    endtask

    task automatic check_reset(input string nm);
        check1({nm, "_memReq"}, memReq, 1'b0);
        check ({nm, "_memAddr"}, memAddr, 32'h0);
        check1({nm, "_pcEn"}, pcEn, 1'b0);
        check1({nm, "_instrValid"}, instrValid, 1'b0);
        check ({nm, "_instrOut"}, instrOut, NOP);
        check ({nm, "_instrPc"}, instrPc, 32'h0);
        check1({nm, "_fetchFault"}, fetchFault, 1'b0);
    endtask

    initial begin
        logic [31:0] cap_out, cap_pc;
        int          pcen_seen;

        repeat (2) tick();
        check_reset("reset");
        load_stream(32'h0);
        rstN = 1'b1;
        fast_mode = 1;
        repeat (40) tick();
        fast_mode = 0;

        // Decode stall: instruction must stay put, no request, no pcEn.
        force_ready0 = 1;
        tick();
        wait_until(2, "stall_valid");
        tick();
        cap_out = instrOut; cap_pc = instrPc; pcen_seen = 0;
        for (int i = 0; i < 5; i++) begin tick(); if (pcEn) pcen_seen++; end
        check1("stall_valid", instrValid, 1'b1);
        check("stall_out", instrOut, cap_out);
        check("stall_pc", instrPc, cap_pc);
        check1("stall_memreq", memReq, 1'b0);
        check("stall_pcen", 32'(pcen_seen), 32'd0);
        force_ready0 = 0;

        // Flush mid-request with ack three cycles later.
        min_wait = 3; max_wait = 3;
        wait_until(0, "t3_req_low");
        wait_until(1, "t3_req_high");
        dir_target = 32'h20; dir_flush = 1;
        wait_until(6, "t3_flush_sent");
        wait_until(0, "t3_drain_done");
        wait_until(1, "t3_new_req");
        check("t3_new_addr", memAddr, 32'h20);

        // Flush together with memAck, then flush together with instrReady.
        min_wait = 0; max_wait = 0;
        flush_on_ack = 1;
        wait_until(4, "t4_flush_ack");
        repeat (4) tick();
        flush_on_valid = 1;
        wait_until(5, "t4_flush_valid");
        tick();
        check1("t4_dropped_valid", instrValid, 1'b0);
        check("t4_dropped_out", instrOut, NOP);

        // Asynchronous reset in the middle of a request.
        min_wait = 3; max_wait = 3;
        wait_until(0, "t5_req_low");
        wait_until(1, "t5_req_high");
        rstN = 1'b0;
        #1;
        check_reset("async_reset");
        repeat (2) tick();
        check_reset("held_reset");
        load_stream(32'h0);
        rstN = 1'b1;
        min_wait = 0; max_wait = 2; ready_pct = 80;
        repeat (20) tick();

        // Misaligned PC.
        dir_target = 32'h22; dir_flush = 1;
        wait_until(6, "t6_flush_sent");
`ifdef IFETCH_MISALIGN_TRAP_EN
        wait_until(3, "t6_fault");
        check1("t6_fault_valid", instrValid, 1'b1);
        check1("t6_fault_memreq", memReq, 1'b0);
        check("t6_fault_out", instrOut, NOP);
        check("t6_fault_pc", instrPc, 32'h22);
        ready_pct = 100;
        repeat (5) tick();
        check1("t6_fault_held", fetchFault, 1'b1);
        check1("t6_fault_valid_held", instrValid, 1'b1);
        dir_target = 32'h40; dir_flush = 1;
        wait_until(6, "t6_unflush_sent");
        repeat (2) tick();
        check1("t6_fault_cleared", fetchFault, 1'b0);
`else
        wait_until(0, "t6_req_low");
        wait_until(1, "t6_req_high");
        check("t6_aligned_addr", memAddr, 32'h20);
`endif

        // Randomised traffic.
        ready_pct = 70; flush_pct = 4; min_wait = 0; max_wait = 3;
        repeat (2000) tick();
        flush_pct = 0;
        repeat (10) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
